// File: rtl/axis_cmd_pkg.sv
// Shared definitions for the axis command sequencer: FSM encoding, channel
// direction codes and the packed command record width.
package axis_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      LEN  = 2'd2,
      GAP  = 2'd3
   } state_e;

   localparam logic DIR_WR = 1'b0;
   localparam logic DIR_RD = 1'b1;

   // Command record layout: {dir, addr, len}
   function automatic int cmd_width(input int dwidth);
      return 1 + 2 * dwidth;
   endfunction

endpackage

// File: rtl/axis_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags.
// A push while full is dropped; the producer is expected to honour ~full.
module axis_cmd_fifo #(
   parameter int AW = 2,
   parameter int W  = 65
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rptr_q];

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop)
         count_d = count_q + 1'b1;
      else if (!do_push && do_pop)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full    <= 1'b0;
         empty   <= 1'b1;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_d;
         full    <= (count_d == (AW+1)'(DEPTH));
         empty   <= (count_d == '0);
      end
   end

   // NOTE: storage has no reset; entries are only read once the pointers say they are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= wdata;
   end

endmodule

// File: rtl/axis_cmd_seq.sv
// Command sequencer: serialises queued DMA commands into cfg beats and tracks
// per-channel completion. Optional watchdog enabled by AXIS_CMD_TIMEOUT_EN.
module axis_cmd_seq
   import axis_cmd_pkg::*;
#(
   parameter int CMD_DEPTH_AW  = 2,
   parameter int CONFIG_ID_WR  = 1,
   parameter int CONFIG_ID_RD  = 2,
   parameter int CONFIG_AWIDTH = 5,
   parameter int CONFIG_DWIDTH = 32,
   parameter int CFG_GAP       = 1,
   parameter int TIMEOUT_CYC   = 2**20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_dir,
   input  logic [CONFIG_DWIDTH-1:0] cmd_addr,
   input  logic [CONFIG_DWIDTH-1:0] cmd_len,
   output logic [CONFIG_AWIDTH-1:0] cfg_addr,
   output logic [CONFIG_DWIDTH-1:0] cfg_data,
   output logic                     cfg_valid,
   input  logic                     wr_hs,
   input  logic                     rd_hs,
   output logic                     wr_busy,
   output logic                     rd_busy,
   output logic                     wr_done,
   output logic                     rd_done,
   output logic                     err
);

   localparam int DW    = CONFIG_DWIDTH;
   localparam int CMD_W = cmd_width(CONFIG_DWIDTH);

   logic [CMD_W-1:0]         head;
   logic                     fifo_full, fifo_empty, pop;
   logic                     head_dir;
   logic [DW-1:0]            head_addr, head_len;
   logic [CONFIG_AWIDTH-1:0] head_id;

   state_e                   state_q, state_d;
   logic [3:0]               gap_q, gap_d;
   logic                     cfg_valid_d;
   logic [CONFIG_AWIDTH-1:0] cfg_addr_d;
   logic [DW-1:0]            cfg_data_d;
   logic                     load, zero_pop;

   logic [1:0]               hs, busy_q, done_q, timeout_hit;
   logic [DW-1:0]            rem_q [2];

   axis_cmd_fifo #(.AW(CMD_DEPTH_AW), .W(CMD_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .wdata ({cmd_dir, cmd_addr, cmd_len}),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign cmd_ready = ~fifo_full;
   assign head_dir  = head[CMD_W-1];
   assign head_addr = head[2*DW-1:DW];
   assign head_len  = head[DW-1:0];
   assign head_id   = (head_dir == DIR_RD) ? CONFIG_AWIDTH'(CONFIG_ID_RD)
                                           : CONFIG_AWIDTH'(CONFIG_ID_WR);
   assign hs        = {rd_hs, wr_hs};

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      gap_d       = '0;
      pop         = 1'b0;
      load        = 1'b0;
      zero_pop    = 1'b0;
      cfg_valid_d = 1'b0;
      cfg_addr_d  = '0;
      cfg_data_d  = '0;
      case (state_q)
         IDLE: begin
            // Head-of-line blocking: a busy channel stalls everything behind it.
            if (!fifo_empty && !busy_q[head_dir]) begin
               if (head_len == '0) begin
                  pop      = 1'b1;
                  zero_pop = 1'b1;
               end else begin
                  state_d     = ADDR;
                  cfg_valid_d = 1'b1;
                  cfg_addr_d  = head_id;
                  cfg_data_d  = head_addr;
               end
            end
         end
         ADDR: begin
            state_d     = LEN;
            cfg_valid_d = 1'b1;
            cfg_addr_d  = head_id;
            cfg_data_d  = head_len;
         end
         LEN: begin
            pop     = 1'b1;
            load    = 1'b1;
            state_d = (CFG_GAP == 0) ? IDLE : GAP;
         end
         GAP: begin
            if (gap_q == 4'(CFG_GAP - 1))
               state_d = IDLE;
            else
               gap_d = gap_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gap_q     <= '0;
         cfg_valid <= 1'b0;
         cfg_addr  <= '0;
         cfg_data  <= '0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         cfg_valid <= cfg_valid_d;
         cfg_addr  <= cfg_addr_d;
         cfg_data  <= cfg_data_d;
      end
   end

   // Per-channel outstanding-command tracking; busy is only set after the LEN beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         done_q <= '0;
         for (int ch = 0; ch < 2; ch++) rem_q[ch] <= '0;
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            done_q[ch] <= 1'b0;
            if (load && head_dir == 1'(ch)) begin
               busy_q[ch] <= 1'b1;
               rem_q[ch]  <= head_len;
            end else if (busy_q[ch] && hs[ch]) begin
               rem_q[ch] <= rem_q[ch] - 1'b1;
               if (rem_q[ch] == DW'(1)) begin
                  busy_q[ch] <= 1'b0;
                  done_q[ch] <= 1'b1;
               end
            end else if (timeout_hit[ch]) begin
               busy_q[ch] <= 1'b0;
            end
            if (zero_pop && head_dir == 1'(ch)) done_q[ch] <= 1'b1;
         end
      end
   end

`ifdef AXIS_CMD_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

   logic [WD_W-1:0] wd_cnt_q [2];

   always_comb begin
      for (int ch = 0; ch < 2; ch++)
         timeout_hit[ch] = busy_q[ch] && !hs[ch] && (wd_cnt_q[ch] == WD_W'(TIMEOUT_CYC - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
         for (int ch = 0; ch < 2; ch++) wd_cnt_q[ch] <= '0;
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            if (!busy_q[ch] || hs[ch])
               wd_cnt_q[ch] <= '0;
            else
               wd_cnt_q[ch] <= wd_cnt_q[ch] + 1'b1;
            if (timeout_hit[ch]) err <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = '0;
   assign err         = 1'b0;
`endif

   assign wr_busy = busy_q[DIR_WR];
   assign rd_busy = busy_q[DIR_RD];
   assign wr_done = done_q[DIR_WR];
   assign rd_done = done_q[DIR_RD];

endmodule

// File: tb/tb_axis_cmd_seq.sv
// Directed bench for axis_cmd_seq; covers the watchdog when built with AXIS_CMD_TIMEOUT_EN.
module tb_axis_cmd_seq;

   logic        clk, rst_n;
   logic        cmd_valid, cmd_ready, cmd_dir;
   logic [31:0] cmd_addr, cmd_len;
   logic [4:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        cfg_valid;
   logic        wr_hs, rd_hs, wr_busy, rd_busy, wr_done, rd_done, err;

   int checks = 0;
   int errors = 0;

   axis_cmd_seq #(.TIMEOUT_CYC(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dir   (cmd_dir),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_valid (cfg_valid),
      .wr_hs     (wr_hs),
      .rd_hs     (rd_hs),
      .wr_busy   (wr_busy),
      .rd_busy   (rd_busy),
      .wr_done   (wr_done),
      .rd_done   (rd_done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer a command, wait (bounded) for acceptance, then withdraw it.
   task automatic push(input logic dir, input logic [31:0] addr, input logic [31:0] len);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_dir   = dir;
      cmd_addr  = addr;
      cmd_len   = len;
      while (!cmd_ready && n < 50) begin
         step();
         n++;
      end
      check("push_ready", cmd_ready, 1);
      step();
      cmd_valid = 1'b0;
   endtask

   // Complete n single-word write commands one after another.
   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         int k = 0;
         while (!wr_busy && k < 20) begin
            step();
            k++;
         end
         check("drain_busy", wr_busy, 1);
         wr_hs = 1'b1;
         step();
         wr_hs = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout got 0 expected 1");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic seen;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_hs = 1'b0; rd_hs = 1'b0;
      step(); step();
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_outs", {cfg_valid, cfg_addr, wr_busy, rd_busy, wr_done, rd_done, err}, 0);
      check("rst_cfg_data", cfg_data, 0);
      rst_n = 1'b1;
      step();

      // 1: single write, cfg beats on consecutive cycles, done after 4th hs
      push(1'b0, 32'h1000, 32'd4);
      check("t1_idle_valid", cfg_valid, 0);
      step();
      check("t1_addr_beat", {cfg_valid, cfg_addr}, {1'b1, 5'd1});
      check("t1_addr_data", cfg_data, 32'h1000);
      step();
      check("t1_len_beat", {cfg_valid, cfg_addr, wr_busy}, {1'b1, 5'd1, 1'b0});
      check("t1_len_data", cfg_data, 32'd4);
      step();
      check("t1_gap", {cfg_valid, wr_busy}, 2'b01);
      check("t1_gap_data", cfg_data, 0);
      wr_hs = 1'b1;
      repeat (3) step();
      check("t1_before_done", {wr_done, wr_busy}, 2'b01);
      step();
      wr_hs = 1'b0;
      check("t1_done", {wr_done, wr_busy}, 2'b10);
      step();
      check("t1_done_pulse", wr_done, 0);

      // 2: write len 8 then read len 2, concurrent channels
      push(1'b0, 32'h2000, 32'd8);
      push(1'b1, 32'h3000, 32'd2);
      check("t2_wr_addr", {cfg_valid, cfg_addr}, {1'b1, 5'd1});
      check("t2_wr_addr_data", cfg_data, 32'h2000);
      step();
      check("t2_wr_len_data", cfg_data, 32'd8);
      step();
      check("t2_gap", cfg_valid, 0);
      step();
      check("t2_idle", cfg_valid, 0);
      step();
      check("t2_rd_addr", {cfg_valid, cfg_addr}, {1'b1, 5'd2});
      check("t2_rd_addr_data", cfg_data, 32'h3000);
      step();
      check("t2_rd_len_data", cfg_data, 32'd2);
      step();
      check("t2_both_busy", {wr_busy, rd_busy}, 2'b11);
      wr_hs = 1'b1; rd_hs = 1'b1;
      step(); step();
      rd_hs = 1'b0;
      check("t2_rd_done", {rd_done, rd_busy, wr_done, wr_busy}, 4'b1001);
      repeat (6) step();
      wr_hs = 1'b0;
      check("t2_wr_done", {wr_done, wr_busy, rd_done}, 3'b100);
      step();

      // 3: second write held until the first completes
      push(1'b0, 32'h5000, 32'd1);
      push(1'b0, 32'h6000, 32'd3);
      check("t3_first_addr", cfg_data, 32'h5000);
      step(); step(); step();
      check("t3_held_a", {cfg_valid, wr_busy}, 2'b01);
      step();
      check("t3_held_b", cfg_valid, 0);
      wr_hs = 1'b1;
      step();
      wr_hs = 1'b0;
      check("t3_first_done", {wr_done, cfg_valid}, 2'b10);
      step();
      check("t3_second_addr", {cfg_valid, cfg_addr}, {1'b1, 5'd1});
      check("t3_second_addr_data", cfg_data, 32'h6000);
      step();
      check("t3_second_len_data", {cfg_valid, cfg_data}, {1'b1, 32'd3});
      step();
      wr_hs = 1'b1;
      repeat (3) step();
      wr_hs = 1'b0;
      check("t3_second_done", wr_done, 1);
      step();

      // 4: FIFO full, pop-while-full keeps ready low that cycle
      push(1'b0, 32'h7000, 32'd1);
      step(); step(); step();
      check("t4_busy", wr_busy, 1);
      push(1'b0, 32'h7100, 32'd1);
      push(1'b0, 32'h7200, 32'd1);
      push(1'b0, 32'h7300, 32'd1);
      push(1'b0, 32'h7400, 32'd1);
      check("t4_full", cmd_ready, 0);
      cmd_valid = 1'b1; cmd_addr = 32'h7500; cmd_len = 32'd1;
      wr_hs = 1'b1;
      step();
      wr_hs = 1'b0;
      check("t4_first_done", {wr_done, cmd_ready}, 2'b10);
      step();
      check("t4_next_addr", {cfg_valid, cmd_ready}, 2'b10);
      check("t4_next_addr_data", cfg_data, 32'h7100);
      step();
      check("t4_pop_full_ready", {cfg_valid, cmd_ready}, 2'b10);
      step();
      check("t4_ready_back", cmd_ready, 1);
      step();
      cmd_valid = 1'b0;
      check("t4_full_again", cmd_ready, 0);
      drain(5);
      repeat (6) step();
      check("t4_drained", {cmd_ready, wr_busy, cfg_valid}, 3'b100);

      // 5: zero-length command
      push(1'b0, 32'h8000, 32'd0);
      check("t5_c1", {cfg_valid, wr_busy, wr_done}, 3'b000);
      step();
      check("t5_c2", {cfg_valid, wr_busy, wr_done}, 3'b001);
      step();
      check("t5_c3", {cfg_valid, wr_busy, wr_done}, 3'b000);

      // 6: hs while not busy (including ADDR/LEN cycles) is ignored
      wr_hs = 1'b1;
      push(1'b0, 32'h9000, 32'd2);
      step(); step();
      check("t6_len_nobusy", {wr_busy, wr_done}, 2'b00);
      step();
      check("t6_busy", {wr_busy, wr_done}, 2'b10);
      step();
      check("t6_one_left", {wr_busy, wr_done}, 2'b10);
      step();
      wr_hs = 1'b0;
      check("t6_done", {wr_busy, wr_done}, 2'b01);
      step();

      // 7: reset mid-command aborts and empties the queue
      push(1'b0, 32'hA000, 32'd4);
      push(1'b0, 32'hB000, 32'd1);
      step(); step();
      wr_hs = 1'b1;
      step(); step();
      wr_hs = 1'b0;
      check("t7_busy_pre", wr_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t7_abort", {wr_busy, cmd_ready, cfg_valid, wr_done}, 4'b0100);
      step();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         seen = seen | cfg_valid | wr_done | wr_busy;
      end
      check("t7_quiet_after_rst", seen, 0);

`ifdef AXIS_CMD_TIMEOUT_EN
      // 8: watchdog fires after 64 busy cycles without hs
      push(1'b0, 32'hC000, 32'd1);
      step(); step(); step();
      check("t8_busy", {wr_busy, err}, 2'b10);
      repeat (63) step();
      check("t8_before_timeout", {wr_busy, err}, 2'b10);
      step();
      check("t8_timeout", {wr_busy, err, wr_done}, 3'b010);
      repeat (3) step();
      check("t8_sticky", err, 1);
`else
      check("t8_err_tied", err, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
